// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam int DMEM_DEPTH   = 128;
  localparam int DMEM_LATENCY = 2;
  localparam int BYTE_LANES   = 4;

  // Access fault: misaligned, or word index beyond the storage range.
  function automatic logic addr_err(input logic [63:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ((addr >> 2) >= 64'(depth));
  endfunction
endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 word storage: async-low clear, byte-enabled synchronous write, combinational read.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    we_i,
  input  logic [BYTE_LANES-1:0]   be_i,
  input  logic [IDX_W-1:0]        idx_i,
  input  logic [8*BYTE_LANES-1:0] wdata_i,
  output logic [8*BYTE_LANES-1:0] rdata_o
);
  logic [8*BYTE_LANES-1:0] r_mem [DEPTH];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (we_i) begin
      for (int b = 0; b < BYTE_LANES; b++)
        if (be_i[b]) r_mem[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
  end

  assign rdata_o = r_mem[idx_i];
endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory target: request handshake, fixed access latency,
// byte-enabled store / word load, held response until the requester takes it.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = DMEM_DEPTH,
  parameter int LATENCY    = DMEM_LATENCY
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [BYTE_LANES-1:0] req_be_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [BYTE_LANES-1:0] r_be;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;

  logic                  w_accept, w_access, w_err, w_we;
  logic [IDX_W-1:0]      w_idx;
  logic [DATA_WIDTH-1:0] w_rd, w_merged;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_access    = 1'b0;
    case (r_state)
      S_IDLE: if (req_valid_i) begin
        w_accept    = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: if (r_cnt == '0) begin
        w_access    = 1'b1;
        w_state_nxt = S_RESP;
      end
      S_RESP: if (rsp_ready_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_idx = r_addr[IDX_W+1:2];
  assign w_err = addr_err(64'(r_addr), DEPTH);
  assign w_we  = w_access && r_write && !w_err;

  // Post-write word: what the store response reports and what the array will hold.
  always_comb begin
    w_merged = w_rd;
    for (int b = 0; b < BYTE_LANES; b++)
      if (r_write && r_be[b]) w_merged[8*b +: 8] = r_wdata[8*b +: 8];
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt   <= CNT_W'(LATENCY - 1);
        r_write <= req_write_i;
        r_addr  <= req_addr_i;
        r_wdata <= req_wdata_i;
        r_be    <= req_be_i;
      end else if (r_state == S_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_access) begin
        r_rdata <= w_err ? '0 : w_merged;
        r_err   <= w_err;
      end else if (r_state == S_RESP && rsp_ready_i) begin
        r_rdata <= '0;
        r_err   <= 1'b0;
      end
    end
  end

  dmem_array #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (w_we),
    .be_i    (r_be),
    .idx_i   (w_idx),
    .wdata_i (r_wdata),
    .rdata_o (w_rd)
  );

  assign req_ready_o = (r_state == S_IDLE);
  assign rsp_valid_o = (r_state == S_RESP);
  assign rsp_rdata_o = r_rdata;
  assign rsp_err_o   = r_err;
endmodule
